// File: rtl/ram_scan_reader_pkg.sv
// ram_scan_reader_pkg
// Shared sizes and the scan FSM state encoding for ram_scan_reader and its
// dwell timer. No ports; import with "import ram_scan_reader_pkg::*;".
package ram_scan_reader_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 32;

    // Highest RAM address; expiry here either ends or wraps the scan.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DWELL,
        DONE
    } state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// scan_dwell_timer
// Down-counter that sets how long each captured word stays on display.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (count cleared to 0)
//   load          : load load_value (takes priority over counting)
//   load_value    : reload value, normally DWELL_CYCLES-1
//   hold          : freeze the count; expiry then comes only from force_expire
//   force_expire  : forced expiry, honoured only while hold is high
//   expired       : combinational expiry indication
module scan_dwell_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    input  logic             force_expire,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // While held the count is frozen, so natural expiry is masked and only
    // the forced path can end the dwell.
    assign expired = hold ? force_expire : (count_q == '0);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves count_d
        // unassigned, which would otherwise infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (!hold && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader
// Walks a 32x8 RAM from address 0 to 31. Each word is read, captured and
// held for DWELL_CYCLES cycles for display. pause freezes the dwell, and
// step advances one address while paused. LOOP=1 wraps to address 0
// instead of stopping in DONE.
// Optional feature: define SCAN_CHECKSUM_EN to add the checksum output, the
// mod-256 sum of words captured since the last start or wrap.
// Ports:
//   CLOCK_50, reset : clock, synchronous active-high reset
//   start           : pulse; begins a scan from IDLE or DONE
//   pause, step     : dwell freeze level / single-advance pulse
//   ram_q           : RAM read data, one cycle after ram_addr
//   ram_addr        : RAM read address (always the address counter)
//   ram_wren        : RAM write enable, tied to 0
//   cur_addr        : address of the displayed word
//   cur_data        : displayed word
//   data_valid      : cur_addr/cur_data hold a captured word
//   busy, done      : scan active / scan finished
//   checksum        : (SCAN_CHECKSUM_EN only) running sum of captured words
module ram_scan_reader
    import ram_scan_reader_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000,
    parameter int LOOP         = 0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_data,
    output logic              data_valid,
    output logic              busy,
`ifdef SCAN_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    localparam int TIMER_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] counter_q,    counter_d;
    logic [ADDR_W-1:0] cur_addr_q,   cur_addr_d;
    logic [DATA_W-1:0] cur_data_q,   cur_data_d;
    logic              data_valid_q, data_valid_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
`ifdef SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q,   checksum_d;
`endif

    logic timer_load;
    logic timer_hold;
    logic timer_force;
    logic timer_expired;

    // Outside DWELL the timer is held with no force, so it can never expire
    // there; pause/step therefore cannot disturb an in-flight read.
    assign timer_hold  = pause || (state_q != DWELL);
    assign timer_force = pause && step && (state_q == DWELL);

    scan_dwell_timer #(
        .WIDTH (TIMER_W)
    ) u_dwell_timer (
        .clk          (CLOCK_50),
        .reset        (reset),
        .load         (timer_load),
        .load_value   (DWELL_LOAD),
        .hold         (timer_hold),
        .force_expire (timer_force),
        .expired      (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        cur_addr_d   = cur_addr_q;
        cur_data_d   = cur_data_q;
        data_valid_d = data_valid_q;
        timer_load   = 1'b0;
`ifdef SCAN_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = ISSUE;
                    counter_d  = '0;
`ifdef SCAN_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  state_d = CAPTURE;
            CAPTURE: begin
                cur_data_d   = ram_q;
                cur_addr_d   = counter_q;
                data_valid_d = 1'b1;
                timer_load   = 1'b1;
`ifdef SCAN_CHECKSUM_EN
                checksum_d   = checksum_q + ram_q;
`endif
                state_d      = DWELL;
            end
            DWELL: begin
                if (timer_expired) begin
                    if (counter_q != LAST_ADDR) begin
                        counter_d = counter_q + 1'b1;
                        state_d   = ISSUE;
                    end else if (LOOP != 0) begin
                        counter_d  = '0;
`ifdef SCAN_CHECKSUM_EN
                        checksum_d = '0;
`endif
                        state_d    = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up
        // with the state register.
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            cur_addr_q   <= '0;
            cur_data_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            cur_addr_q   <= cur_addr_d;
            cur_data_q   <= cur_data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SCAN_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign ram_addr   = counter_q;
    assign ram_wren   = 1'b0;
    assign cur_addr   = cur_addr_q;
    assign cur_data   = cur_data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SCAN_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader
// Scoreboard bench for ram_scan_reader with DWELL_CYCLES=4 and a RAM model
// preloaded with mem[i] = i + 8'h10. One instance runs with LOOP=0, and a
// second with LOOP=1 covers the wrap.
module tb_ram_scan_reader;

    localparam int DWELL = 4;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       start_l  = 1'b0;
    logic       pause    = 1'b0;
    logic       step     = 1'b0;

    logic [7:0] ram_q,      ram_q_l;
    logic [4:0] ram_addr,   ram_addr_l;
    logic       ram_wren,   ram_wren_l;
    logic [4:0] cur_addr,   cur_addr_l;
    logic [7:0] cur_data,   cur_data_l;
    logic       data_valid, data_valid_l;
    logic       busy,       busy_l;
    logic       done,       done_l;
`ifdef SCAN_CHECKSUM_EN
    logic [7:0] checksum,   checksum_l;
`endif

    logic [7:0] mem [32];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    exp_t       exp_q [$];
    logic [7:0] model_sum   = 8'h00;
    logic       prev_valid  = 1'b0;
    logic [4:0] prev_addr   = 5'd0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ram_scan_reader #(.DWELL_CYCLES(DWELL), .LOOP(0)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .step       (step),
        .ram_q      (ram_q),
        .ram_addr   (ram_addr),
        .ram_wren   (ram_wren),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .data_valid (data_valid),
        .busy       (busy),
`ifdef SCAN_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    ram_scan_reader #(.DWELL_CYCLES(DWELL), .LOOP(1)) dut_loop (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start_l),
        .pause      (pause),
        .step       (step),
        .ram_q      (ram_q_l),
        .ram_addr   (ram_addr_l),
        .ram_wren   (ram_wren_l),
        .cur_addr   (cur_addr_l),
        .cur_data   (cur_data_l),
        .data_valid (data_valid_l),
        .busy       (busy_l),
`ifdef SCAN_CHECKSUM_EN
        .checksum   (checksum_l),
`endif
        .done       (done_l)
    );

    // Synchronous-read RAM models, one cycle of latency.
    always @(posedge CLOCK_50) begin
        ram_q   <= mem[ram_addr];
        ram_q_l <= mem[ram_addr_l];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Push the full expected capture sequence, then pulse start.
    task automatic start_scan();
        exp_t e;
        exp_q.delete();
        model_sum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            e.addr = 5'(i);
            e.data = 8'h10 + 8'(i);
            exp_q.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_addr(input logic [4:0] a, input int budget);
        int n = 0;
        while (cur_addr !== a && n < budget) begin
            tick();
            n++;
        end
        check("wait_addr", 32'(cur_addr), 32'(a));
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_addr",   32'(ram_addr),   0);
        check("rst_cur_addr",   32'(cur_addr),   0);
        check("rst_cur_data",   32'(cur_data),   0);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_busy",       32'(busy),       0);
        check("rst_done",       32'(done),       0);
        check("rst_ram_wren",   32'(ram_wren),   0);
`ifdef SCAN_CHECKSUM_EN
        check("rst_checksum",   32'(checksum),   0);
`endif
    endtask

    // Scoreboard monitor: a new captured word is a data_valid rise or an
    // address change; each one must match the head of the expected queue.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (data_valid && (!prev_valid || cur_addr != prev_addr)) begin
                if (exp_q.size() == 0) begin
                    check("sb_pending", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(cur_addr), 32'(e.addr));
                    check("sb_data", 32'(cur_data), 32'(e.data));
                    model_sum = model_sum + e.data;
                end
            end
            prev_valid = data_valid;
            prev_addr  = cur_addr;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);

        tick(3);
        check_reset_outputs();
        reset = 1'b0;
        tick(2);
        check("idle_busy", 32'(busy), 0);

        // First word lands on the third edge after start; next 7 cycles later.
        start_scan();
        check("start_busy", 32'(busy), 1);
        tick();
        check("start_ram_addr", 32'(ram_addr), 0);
        tick();
        check("pre_capture_valid", 32'(data_valid), 0);
        tick();
        check("first_data",  32'(cur_data),   32'h10);
        check("first_addr",  32'(cur_addr),   0);
        check("first_valid", 32'(data_valid), 1);
        tick(DWELL + 2);
        check("period_hold", 32'(cur_addr), 0);
        tick();
        check("period_next", 32'(cur_addr), 1);

        // Pause freezes the dwell at address 5; step forces expiry.
        wait_addr(5'd5, 40);
        pause = 1'b1;
        tick(20);
        check("pause_hold_addr", 32'(cur_addr), 5);
        check("pause_busy",      32'(busy),     1);
        step = 1'b1;
        tick();
        step  = 1'b0;
        pause = 1'b0;
        check("step_issue_addr", 32'(ram_addr), 6);
        check("step_cur_addr",   32'(cur_addr), 5);
        tick(3);
        check("step_captured", 32'(cur_addr), 6);

        // Step without pause is ignored: normal period.
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(DWELL + 1);
        check("step_ignored", 32'(cur_addr), 6);
        tick();
        check("step_ignored_next", 32'(cur_addr), 7);

        // Start while busy is ignored.
        wait_addr(5'd10, 40);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(DWELL + 1);
        check("busy_start_hold", 32'(cur_addr), 10);
        tick();
        check("busy_start_next", 32'(cur_addr), 11);

        // Reset mid-scan.
        wait_addr(5'd12, 40);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        reset = 1'b0;
        exp_q.delete();
        tick(DWELL + 3);
        check("post_reset_idle", 32'(busy), 0);
        check("post_reset_addr", 32'(cur_addr), 0);

        // Full run to DONE.
        start_scan();
        n = 0;
        while (!done && n < 32 * (DWELL + 3) + 20) begin
            tick();
            n++;
        end
        check("full_done",     32'(done),       1);
        check("full_busy",     32'(busy),       0);
        check("full_cur_addr", 32'(cur_addr),   31);
        check("full_cur_data", 32'(cur_data),   32'h2F);
        check("full_valid",    32'(data_valid), 1);
        check("full_sb_drain", 32'(exp_q.size()), 0);
`ifdef SCAN_CHECKSUM_EN
        check("full_checksum", 32'(checksum), 32'(model_sum));
`endif
        tick(5);
        check("done_hold_addr", 32'(cur_addr), 31);
        check("done_hold",      32'(done),     1);

        // Restart from DONE.
        start_scan();
        check("restart_busy",     32'(busy),     1);
        check("restart_done",     32'(done),     0);
        check("restart_ram_addr", 32'(ram_addr), 0);
        tick(3);
        check("restart_data", 32'(cur_data), 32'h10);
        check("restart_addr", 32'(cur_addr), 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();

        // LOOP=1 instance wraps 31 -> 0.
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        n = 0;
        while (cur_addr_l !== 5'd31 && n < 32 * (DWELL + 3) + 20) begin
            tick();
            n++;
        end
        check("loop_reach_31", 32'(cur_addr_l), 31);
        check("loop_data_31",  32'(cur_data_l), 32'h2F);
        tick(DWELL + 2);
        check("loop_hold_31", 32'(cur_addr_l), 31);
        tick();
        check("loop_wrap_addr", 32'(cur_addr_l), 0);
        check("loop_wrap_data", 32'(cur_data_l), 32'h10);
        check("loop_busy",      32'(busy_l),     1);
        check("loop_done",      32'(done_l),     0);
`ifdef SCAN_CHECKSUM_EN
        check("loop_checksum", 32'(checksum_l), 32'h10);
`endif
        check("loop_ram_wren", 32'(ram_wren_l), 0);
        check("main_ram_wren", 32'(ram_wren),   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
